// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared helpers for the SPU control-path blocks: counter sizing and boolean-string decoding.
// Pure functions only; no state, no latency.
package elixirchip_es1_spu_pkg;

  function automatic int spu_cnt_bits(input int n);
    int b;
    b = $clog2(n + 1);
    return (b < 1) ? 1 : b;
  endfunction

  // Parameters arrive as "true"/"false" strings from the integration flow.
  function automatic bit spu_str_true(input string s);
    return (s == "true");
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_ctl_valid_stage.sv
// One valid/data register stage, 1 cke-qualified cycle of latency; holds on cke=0.
// clear drops the valids regardless of cke; data is cleared only when DATA_RESET="true".
module elixirchip_es1_spu_ctl_valid_stage
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    CHANNELS   = 1,
  parameter int    DATA_BITS  = 8,
  parameter string DATA_RESET = "false",
  parameter string DEVICE     = "RTL"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic                 clear,
  input  logic [CHANNELS-1:0]  in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic [CHANNELS-1:0]  out_valid,
  output logic [DATA_BITS-1:0] out_data
);

  logic [CHANNELS-1:0]  valid_q;
  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      valid_q <= '0;
    else if (clear) valid_q <= '0;
    else if (cke)   valid_q <= in_valid;
  end

  generate
    if (spu_str_true(DATA_RESET)) begin : g_data_rst
      always_ff @(posedge clk or posedge reset) begin
        if (reset)      data_q <= '0;
        else if (clear) data_q <= '0;
        else if (cke)   data_q <= in_data;
      end
    end else begin : g_data_norst
      // No reset on the payload so it can map to plain (SRL-friendly) flops.
      always_ff @(posedge clk) begin
        if (cke) data_q <= in_data;
      end
    end
  endgenerate

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/elixirchip_es1_spu_ctl_valid_pipe.sv
// Multi-channel valid/data delay line, LATENCY cke-qualified cycles (0 = combinational bypass).
// No backpressure: cke=0 freezes the whole pipe, clear flushes in-flight valids.
module elixirchip_es1_spu_ctl_valid_pipe
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY    = 3,
  parameter int    CHANNELS   = 1,
  parameter int    DATA_BITS  = 8,
  parameter string DATA_RESET = "false",
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cke,
  input  logic                              clear,
  input  logic [CHANNELS-1:0]               s_valid,
  input  logic [DATA_BITS-1:0]              s_data,
  output logic [CHANNELS-1:0]               m_valid,
  output logic [DATA_BITS-1:0]              m_data,
  output logic                              busy,
  output logic [spu_cnt_bits(LATENCY)-1:0]  in_flight
);

  localparam int CW = spu_cnt_bits(LATENCY);

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, reset, cke, clear};
      assign m_valid    = s_valid;
      assign m_data     = s_data;
      assign busy       = 1'b0;
      assign in_flight  = '0;
    end else begin : g_pipe
      logic [CHANNELS-1:0]  vld [0:LATENCY];
      logic [DATA_BITS-1:0] dat [0:LATENCY];
      logic [CW-1:0]        in_flight_q;
      logic [CW-1:0]        in_flight_d;
      logic                 enter;
      logic                 leave;

      assign vld[0] = s_valid;
      assign dat[0] = s_data;

      for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        elixirchip_es1_spu_ctl_valid_stage #(
          .CHANNELS   (CHANNELS),
          .DATA_BITS  (DATA_BITS),
          .DATA_RESET (DATA_RESET),
          .DEVICE     (DEVICE)
        ) u_stage (
          .clk       (clk),
          .reset     (reset),
          .cke       (cke),
          .clear     (clear),
          .in_valid  (vld[k]),
          .in_data   (dat[k]),
          .out_valid (vld[k+1]),
          .out_data  (dat[k+1])
        );
      end

      // A stage is occupied when any channel bit is set; enter+leave on one edge cancel.
      assign enter = |s_valid;
      assign leave = |vld[LATENCY];

      always_comb begin
        in_flight_d = in_flight_q;
        if (enter && !leave)      in_flight_d = in_flight_q + CW'(1);
        else if (!enter && leave) in_flight_d = in_flight_q - CW'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset)      in_flight_q <= '0;
        else if (clear) in_flight_q <= '0;
        else if (cke)   in_flight_q <= in_flight_d;
      end

      assign m_valid   = vld[LATENCY];
      assign m_data    = dat[LATENCY];
      assign in_flight = in_flight_q;
      assign busy      = (in_flight_q != '0);

      if (spu_str_true(SIMULATION)) begin : g_sim_chk
        logic [CW-1:0] occ;
        always_comb begin
          occ = '0;
          for (int k = 1; k <= LATENCY; k++) occ = occ + CW'(vld[k] != '0);
        end
        a_occ: assert property (@(posedge clk) disable iff (reset) in_flight_q == occ)
          else $error("valid_pipe: in_flight %0d disagrees with occupied stages %0d", in_flight_q, occ);
      end
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_ctl_valid_pipe.sv
// Directed bench: LATENCY=3/CHANNELS=2/DATA_BITS=8 pipe plus a LATENCY=0 bypass instance.
module tb_elixirchip_es1_spu_ctl_valid_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cke = 1'b1;
  logic       clear = 1'b0;
  logic [1:0] s_valid = 2'b00;
  logic [7:0] s_data = 8'h00;
  logic [1:0] m_valid;
  logic [7:0] m_data;
  logic       busy;
  logic [1:0] in_flight;

  logic [1:0] s_valid0 = 2'b00;
  logic [7:0] s_data0 = 8'h00;
  logic [1:0] m_valid0;
  logic [7:0] m_data0;
  logic       busy0;
  logic [0:0] in_flight0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elixirchip_es1_spu_ctl_valid_pipe #(
    .LATENCY(3), .CHANNELS(2), .DATA_BITS(8),
    .DATA_RESET("true"), .DEVICE("RTL"), .SIMULATION("true"), .DEBUG("false")
  ) dut (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .busy(busy), .in_flight(in_flight)
  );

  elixirchip_es1_spu_ctl_valid_pipe #(
    .LATENCY(0), .CHANNELS(2), .DATA_BITS(8),
    .DATA_RESET("false"), .DEVICE("RTL"), .SIMULATION("true"), .DEBUG("false")
  ) dut0 (
    .clk(clk), .reset(reset), .cke(cke), .clear(clear),
    .s_valid(s_valid0), .s_data(s_data0),
    .m_valid(m_valid0), .m_data(m_data0), .busy(busy0), .in_flight(in_flight0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] emv, input logic [7:0] emd,
                         input logic [1:0] eif);
    chk({tag, ".m_valid"},   32'(m_valid),   32'(emv));
    chk({tag, ".m_data"},    32'(m_data),    32'(emd));
    chk({tag, ".in_flight"}, 32'(in_flight), 32'(eif));
    chk({tag, ".busy"},      32'(busy),      32'(eif != 2'd0));
  endtask

  // Drive one cycle of inputs, take one rising edge, check outputs 1 time unit later.
  task automatic step(input string tag, input logic [1:0] v, input logic [7:0] d,
                      input logic ck, input logic cl,
                      input logic [1:0] emv, input logic [7:0] emd, input logic [1:0] eif);
    s_valid = v;
    s_data  = d;
    cke     = ck;
    clear   = cl;
    @(posedge clk);
    #1;
    chk_out(tag, emv, emd, eif);
  endtask

  initial begin
    #12;
    chk_out("reset", 2'b00, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Pulse train
    step("t1e1", 2'b01, 8'hA0, 1, 0, 2'b00, 8'h00, 2'd1);
    step("t1e2", 2'b00, 8'hA1, 1, 0, 2'b00, 8'h00, 2'd1);
    step("t1e3", 2'b10, 8'hA2, 1, 0, 2'b01, 8'hA0, 2'd2);
    step("t1e4", 2'b00, 8'hA3, 1, 0, 2'b00, 8'hA1, 2'd1);
    step("t1e5", 2'b11, 8'hA4, 1, 0, 2'b10, 8'hA2, 2'd2);
    step("t1e6", 2'b00, 8'hB0, 1, 0, 2'b00, 8'hA3, 2'd1);
    step("t1e7", 2'b00, 8'hB1, 1, 0, 2'b11, 8'hA4, 2'd1);
    step("t1e8", 2'b00, 8'hB2, 1, 0, 2'b00, 8'hB0, 2'd0);

    // Stall with two tokens in flight; the inputs offered during the stall must be ignored
    step("t2e1", 2'b01, 8'hC0, 1, 0, 2'b00, 8'hB1, 2'd1);
    step("t2e2", 2'b10, 8'hC1, 1, 0, 2'b00, 8'hB2, 2'd2);
    step("t2s1", 2'b11, 8'hFF, 0, 0, 2'b00, 8'hB2, 2'd2);
    step("t2s2", 2'b11, 8'hFE, 0, 0, 2'b00, 8'hB2, 2'd2);
    step("t2e3", 2'b00, 8'hD0, 1, 0, 2'b01, 8'hC0, 2'd2);
    step("t2e4", 2'b00, 8'hD1, 1, 0, 2'b10, 8'hC1, 2'd1);
    step("t2e5", 2'b00, 8'hD2, 1, 0, 2'b00, 8'hD0, 2'd0);

    // Flush at full occupancy; the 11 token offered with clear never appears
    step("t3e1", 2'b01, 8'hE0, 1, 0, 2'b00, 8'hD1, 2'd1);
    step("t3e2", 2'b10, 8'hE1, 1, 0, 2'b00, 8'hD2, 2'd2);
    step("t3e3", 2'b11, 8'hE2, 1, 0, 2'b01, 8'hE0, 2'd3);
    step("t3cl", 2'b11, 8'hE3, 1, 1, 2'b00, 8'h00, 2'd0);
    step("t3p1", 2'b00, 8'hF0, 1, 0, 2'b00, 8'h00, 2'd0);
    step("t3p2", 2'b00, 8'hF1, 1, 0, 2'b00, 8'h00, 2'd0);
    step("t3p3", 2'b00, 8'hF2, 1, 0, 2'b00, 8'hF0, 2'd0);

    // Clear while stalled still flushes
    step("t4e1", 2'b01, 8'h10, 1, 0, 2'b00, 8'hF1, 2'd1);
    step("t4e2", 2'b00, 8'h11, 1, 0, 2'b00, 8'hF2, 2'd1);
    step("t4cl", 2'b11, 8'h12, 0, 1, 2'b00, 8'h00, 2'd0);
    step("t4p1", 2'b00, 8'h13, 1, 0, 2'b00, 8'h00, 2'd0);

    // Asynchronous reset between edges
    step("t5e1", 2'b11, 8'h20, 1, 0, 2'b00, 8'h00, 2'd1);
    step("t5e2", 2'b01, 8'h21, 1, 0, 2'b00, 8'h13, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t5rst", 2'b00, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    chk_out("t5hold", 2'b00, 8'h00, 2'd0);
    reset = 1'b0;
    step("t5r1", 2'b00, 8'h55, 1, 0, 2'b00, 8'h00, 2'd0);
    step("t5r2", 2'b10, 8'h90, 1, 0, 2'b00, 8'h00, 2'd1);
    step("t5r3", 2'b00, 8'h91, 1, 0, 2'b00, 8'h55, 2'd1);
    step("t5r4", 2'b00, 8'h92, 1, 0, 2'b10, 8'h90, 2'd1);
    step("t5r5", 2'b00, 8'h93, 1, 0, 2'b00, 8'h91, 2'd0);

    // LATENCY=0 bypass
    s_valid0 = 2'b10;
    s_data0  = 8'h5A;
    #1;
    chk("t6a.m_valid",   32'(m_valid0),   32'(2'b10));
    chk("t6a.m_data",    32'(m_data0),    32'(8'h5A));
    chk("t6a.busy",      32'(busy0),      32'(1'b0));
    chk("t6a.in_flight", 32'(in_flight0), 32'(1'b0));
    s_valid0 = 2'b01;
    s_data0  = 8'hA5;
    @(posedge clk);
    #1;
    chk("t6b.m_valid",   32'(m_valid0),   32'(2'b01));
    chk("t6b.m_data",    32'(m_data0),    32'(8'hA5));
    chk("t6b.busy",      32'(busy0),      32'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
